// File: rtl/line_deserializer.sv
// Gathers WORDS beats of WORD_W bits into one cache line, placing them in
// critical-word-first wrap order, and holds the line until it is consumed.
module line_deserializer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    input  logic [IDX_W-1:0]          start_idx,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*WORD_W-1:0]   out_data,
    output logic [IDX_W-1:0]          beat_cnt
);
    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          base_q, base_d;
    logic [WORDS*WORD_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]          widx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        data_d  = data_q;
        // The first beat goes straight to start_idx; base is not yet latched then.
        widx    = (cnt_q == '0) ? start_idx : base_q + cnt_q;
        case (state_q)
            FILL: begin
                if (abort) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (cnt_q == '0) begin
                        base_d = start_idx;
                    end
                    data_d[widx*WORD_W +: WORD_W] = in_data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_line_deserializer.sv
// Directed bench for line_deserializer: a beat-list model predicts handshake,
// counter and line contents every cycle, plus literal spot checks.
module tb_line_deserializer;
    localparam int WORD_W = 32;
    localparam int WORDS  = 8;
    localparam int IDX_W  = 3;
    localparam int LW     = WORDS * WORD_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic [IDX_W-1:0]  start_idx = '0;
    logic              abort = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LW-1:0]     out_data;
    logic [IDX_W-1:0]  beat_cnt;

    int tests = 0;
    int fails = 0;

    line_deserializer #(.WORD_W(WORD_W), .WORDS(WORDS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .start_idx(start_idx), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Model: collect accepted beats as a list, place them once the line is full.
    bit              m_hold = 1'b0;
    int              m_cnt = 0;
    int              m_start = 0;
    logic [WORD_W-1:0] m_beats [WORDS];
    logic [WORD_W-1:0] m_line  [WORDS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 1'b0;
            m_cnt  = 0;
            m_start = 0;
            for (int i = 0; i < WORDS; i++) m_line[i] = '0;
        end else if (!m_hold) begin
            if (abort) begin
                m_cnt = 0;
            end else if (in_valid) begin
                if (m_cnt == 0) m_start = int'(start_idx);
                m_beats[m_cnt] = in_data;
                m_cnt++;
                if (m_cnt == WORDS) begin
                    for (int i = 0; i < WORDS; i++) m_line[(m_start + i) % WORDS] = m_beats[i];
                    m_hold = 1'b1;
                    m_cnt  = 0;
                end
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] word(input int k);
        return out_data[k*WORD_W +: WORD_W];
    endfunction

    always @(negedge clk) begin
        logic [LW-1:0] exp_line;
        for (int k = 0; k < WORDS; k++) exp_line[k*WORD_W +: WORD_W] = m_line[k];
        chk("in_ready", LW'(in_ready), LW'(!m_hold));
        chk("out_valid", LW'(out_valid), LW'(m_hold));
        chk("beat_cnt", LW'(beat_cnt), LW'(m_cnt));
        if (m_hold || !rst_n) chk("out_data", out_data, exp_line);
    end

    task automatic beat(input logic [WORD_W-1:0] d, input logic [IDX_W-1:0] s);
        in_valid = 1'b1; in_data = d; start_idx = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        #3;
        chk("rst out_valid", LW'(out_valid), '0);
        chk("rst beat_cnt", LW'(beat_cnt), '0);
        chk("rst out_data", out_data, '0);
        idle(2);
        rst_n = 1'b1;

        // Linear fill with consumer ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) beat(WORD_W'(i), 3'd0);
        chk("lin valid", LW'(out_valid), LW'(1));
        for (int k = 0; k < 8; k++) chk("lin word", LW'(word(k)), LW'(k));
        chk("lin in_ready low", LW'(in_ready), '0);
        idle(1);
        chk("lin in_ready back", LW'(in_ready), LW'(1));
        out_ready = 1'b0;

        // Wrap fill from word 5
        for (int i = 0; i < 8; i++) beat(32'hA0 + WORD_W'(i), 3'd5);
        chk("wrap w5", LW'(word(5)), LW'(32'hA0));
        chk("wrap w7", LW'(word(7)), LW'(32'hA2));
        chk("wrap w0", LW'(word(0)), LW'(32'hA3));
        chk("wrap w4", LW'(word(4)), LW'(32'hA7));
        out_ready = 1'b1; idle(1); out_ready = 1'b0;

        // Backpressure: beat 0xBB waits through HOLD
        for (int i = 0; i < 8; i++) beat(32'h10 + WORD_W'(i), 3'd0);
        in_valid = 1'b1; in_data = 32'hBB; start_idx = 3'd3;
        idle(10);
        chk("bp in_ready", LW'(in_ready), '0);
        chk("bp held w0", LW'(word(0)), LW'(32'h10));
        out_ready = 1'b1; idle(1); out_ready = 1'b0;
        chk("bp cnt before", LW'(beat_cnt), '0);
        idle(1);
        chk("bp BB taken", LW'(beat_cnt), LW'(1));
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) beat(32'hB0 + WORD_W'(i), 3'd0);
        chk("bp w3", LW'(word(3)), LW'(32'hBB));
        chk("bp w2", LW'(word(2)), LW'(32'hB7));
        out_ready = 1'b1; idle(1); out_ready = 1'b0;

        // Abort after three beats drops the concurrent beat
        for (int i = 0; i < 3; i++) beat(32'hE0 + WORD_W'(i), 3'd6);
        abort = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
        idle(1);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort cnt", LW'(beat_cnt), '0);
        for (int i = 0; i < 8; i++) beat(32'hC0 + WORD_W'(i), 3'd2);
        chk("abort w2", LW'(word(2)), LW'(32'hC0));
        chk("abort w1", LW'(word(1)), LW'(32'hC7));
        chk("abort w6", LW'(word(6)), LW'(32'hC4));
        out_ready = 1'b1; idle(1); out_ready = 1'b0;

        // Gapped input
        for (int i = 0; i < 8; i++) begin
            beat(32'h50 + WORD_W'(i), 3'd1);
            chk("gap cnt", LW'(beat_cnt), LW'((i + 1) % 8));
            chk("gap valid", LW'(out_valid), LW'(i == 7));
            if (i != 7) idle(1);
        end
        chk("gap w0", LW'(word(0)), LW'(32'h57));
        out_ready = 1'b1; idle(1); out_ready = 1'b0;

        // Asynchronous reset mid-line
        for (int i = 0; i < 4; i++) beat(32'h70 + WORD_W'(i), 3'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", LW'(out_valid), '0);
        chk("arst beat_cnt", LW'(beat_cnt), '0);
        chk("arst out_data", out_data, '0);
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) beat(32'h90 + WORD_W'(i), 3'd4);
        chk("arst w4", LW'(word(4)), LW'(32'h90));
        chk("arst w3", LW'(word(3)), LW'(32'h97));
        out_ready = 1'b1; idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
